// File: rtl/load_pkg.sv
// Shared load-unit definitions: funct3 encodings, FSM states and access-size decode.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    RD0,
    RD1,
    RESP
  } state_e;

  // Access size in bytes; funct3[1:0] encodes log2(size).
  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f3_size = 4'd1;
      2'b01:   f3_size = 4'd2;
      2'b10:   f3_size = 4'd4;
      default: f3_size = 4'd8;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic is64);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: f3_legal = 1'b1;
      F3_LD, F3_LWU:                       f3_legal = is64;
      default:                             f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_format.sv
// Combinational load formatter: picks the addressed bytes out of a two-word window
// and sign/zero-extends them according to funct3.
module load_format
  import load_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2*XLEN-1:0] data_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [2:0]        funct3_i,
  output logic [XLEN-1:0]   data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = XLEN'(data_i >> {offset_i, 3'b000});

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = XLEN'($signed(shifted[7:0]));
      F3_LH:   data_o = XLEN'($signed(shifted[15:0]));
      F3_LW:   data_o = XLEN'($signed(shifted[31:0]));
      F3_LBU:  data_o = XLEN'(shifted[7:0]);
      F3_LHU:  data_o = XLEN'(shifted[15:0]);
      F3_LWU:  data_o = XLEN'(shifted[31:0]);
      F3_LD:   data_o = shifted;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// RISC-V load alignment unit: issues one or two aligned DMEM reads and formats the result.
// Build option: MISALIGNED_LOAD_EN lets misaligned loads complete (splitting across words).
module load_align_unit
  import load_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_fault
);

  localparam int unsigned       BYTES    = XLEN / 8;
  localparam int unsigned       OFF_W    = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
  localparam logic              IS64     = (XLEN == 64);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   held_q, held_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              fault_q, fault_d;

  logic              req_bad;
  logic              split;
  logic [ADDR_W-1:0] base_addr;
  logic [2*XLEN-1:0] fmt_in;
  logic [XLEN-1:0]   fmt_out;

`ifdef MISALIGNED_LOAD_EN
  assign req_bad = !f3_legal(req_funct3, IS64);
`else
  logic [3:0] req_size;
  logic       req_aligned;

  assign req_size    = f3_size(req_funct3);
  assign req_aligned = (req_addr[2:0] & 3'(req_size - 4'd1)) == 3'b000;
  assign req_bad     = !f3_legal(req_funct3, IS64) || !req_aligned;
`endif

  // An aligned access never crosses a word, so without the build option split stays low.
  assign split     = (5'(addr_q[OFF_W-1:0]) + 5'(f3_size(f3_q))) > 5'(BYTES);
  assign base_addr = addr_q & ~OFF_MASK;
  assign fmt_in    = (state_q == RD1) ? {mem_rdata, held_q} : {{XLEN{1'b0}}, mem_rdata};

  load_format #(
    .XLEN (XLEN),
    .OFF_W(OFF_W)
  ) u_format (
    .data_i  (fmt_in),
    .offset_i(addr_q[OFF_W-1:0]),
    .funct3_i(f3_q),
    .data_o  (fmt_out)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    held_d    = held_q;
    data_d    = data_q;
    fault_d   = fault_q;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = req_addr & ~OFF_MASK;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d = req_addr;
          f3_d   = req_funct3;
          if (req_bad) begin
            data_d  = '0;
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            mem_rd_en = 1'b1;
            state_d   = RD0;
          end
        end
      end
      RD0: begin
        if (split) begin
          held_d    = mem_rdata;
          mem_rd_en = 1'b1;
          mem_addr  = base_addr + ADDR_W'(BYTES);
          state_d   = RD1;
        end else begin
          data_d  = fmt_out;
          fault_d = 1'b0;
          state_d = RESP;
        end
      end
      RD1: begin
        data_d  = fmt_out;
        fault_d = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      req_ready = 1'b0;
      mem_rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      held_q  <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      held_q  <= held_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign resp_valid = (state_q == RESP) && !rst;
  assign resp_data  = data_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit with XLEN=32 and XLEN=64 instances and a DMEM model.
module tb_load_align_unit;
  import load_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        rv32, rr32, me32, pv32, pf32;
  logic [31:0] ra32, ma32, pd32;
  logic [31:0] md32 = '0;
  logic [2:0]  rf32;

  logic        rv64, rr64, me64, pv64, pf64;
  logic [31:0] ra64, ma64;
  logic [63:0] pd64;
  logic [63:0] md64 = '0;
  logic [2:0]  rf64;

  load_align_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(rr32), .req_addr(ra32),
    .req_funct3(rf32), .mem_rd_en(me32), .mem_addr(ma32), .mem_rdata(md32),
    .resp_valid(pv32), .resp_data(pd32), .resp_fault(pf32)
  );

  load_align_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .req_valid(rv64), .req_ready(rr64), .req_addr(ra64),
    .req_funct3(rf64), .mem_rd_en(me64), .mem_addr(ma64), .mem_rdata(md64),
    .resp_valid(pv64), .resp_data(pd64), .resp_fault(pf64)
  );

  logic [31:0] m32 [logic [31:0]];
  logic [63:0] m64 [logic [31:0]];
  int unsigned rd32 = 0;
  int unsigned rd64 = 0;

  always @(posedge clk) begin
    if (me32) begin
      md32 <= m32.exists(ma32) ? m32[ma32] : 32'h0;
      rd32 <= rd32 + 1;
    end
    if (me64) begin
      md64 <= m64.exists(ma64) ? m64[ma64] : 64'h0;
      rd64 <= rd64 + 1;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    rv32 = 1'b0;
    rv64 = 1'b0;
    #1;
  endtask

  task automatic req32(input logic [31:0] a, input logic [2:0] f);
    @(negedge clk);
    ra32 = a;
    rf32 = f;
    rv32 = 1'b1;
    #1;
  endtask

  task automatic req64(input logic [31:0] a, input logic [2:0] f);
    @(negedge clk);
    ra64 = a;
    rf64 = f;
    rv64 = 1'b1;
    #1;
  endtask

  task automatic run_ok32(input string tag, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] exp_addr, input logic [31:0] exp);
    int unsigned r0;
    r0 = rd32;
    req32(a, f);
    chk({tag, "_T_ready"}, 64'(rr32), 64'd1);
    chk({tag, "_T_rden"}, 64'(me32), 64'd1);
    chk({tag, "_T_addr"}, 64'(ma32), 64'(exp_addr));
    cyc();
    chk({tag, "_T1_valid"}, 64'(pv32), 64'd0);
    chk({tag, "_T1_rden"}, 64'(me32), 64'd0);
    cyc();
    chk({tag, "_T2_valid"}, 64'(pv32), 64'd1);
    chk({tag, "_T2_data"}, 64'(pd32), 64'(exp));
    chk({tag, "_T2_fault"}, 64'(pf32), 64'd0);
    cyc();
    chk({tag, "_T3_valid"}, 64'(pv32), 64'd0);
    chk({tag, "_T3_hold"}, 64'(pd32), 64'(exp));
    chk({tag, "_reads"}, 64'(rd32 - r0), 64'd1);
  endtask

  task automatic run_fault32(input string tag, input logic [31:0] a, input logic [2:0] f);
    int unsigned r0;
    r0 = rd32;
    req32(a, f);
    chk({tag, "_T_rden"}, 64'(me32), 64'd0);
    cyc();
    chk({tag, "_T1_valid"}, 64'(pv32), 64'd1);
    chk({tag, "_T1_fault"}, 64'(pf32), 64'd1);
    chk({tag, "_T1_data"}, 64'(pd32), 64'd0);
    cyc();
    chk({tag, "_T2_valid"}, 64'(pv32), 64'd0);
    chk({tag, "_T2_fhold"}, 64'(pf32), 64'd1);
    chk({tag, "_reads"}, 64'(rd32 - r0), 64'd0);
  endtask

  task automatic run_ok64(input string tag, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] exp_addr, input logic [63:0] exp);
    req64(a, f);
    chk({tag, "_T_rden"}, 64'(me64), 64'd1);
    chk({tag, "_T_addr"}, 64'(ma64), 64'(exp_addr));
    cyc();
    chk({tag, "_T1_valid"}, 64'(pv64), 64'd0);
    cyc();
    chk({tag, "_T2_valid"}, 64'(pv64), 64'd1);
    chk({tag, "_T2_data"}, pd64, exp);
    chk({tag, "_T2_fault"}, 64'(pf64), 64'd0);
    cyc();
    chk({tag, "_T3_valid"}, 64'(pv64), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r0;
    rst  = 1'b1;
    rv32 = 1'b1; ra32 = 32'h100; rf32 = F3_LW;
    rv64 = 1'b1; ra64 = 32'h0;   rf64 = F3_LD;

    // Reset held with requests pending: nothing accepted, no read issued
    @(negedge clk); #1;
    chk("rst_ready32", 64'(rr32), 64'd0);
    chk("rst_rden32", 64'(me32), 64'd0);
    chk("rst_ready64", 64'(rr64), 64'd0);
    chk("rst_rden64", 64'(me64), 64'd0);
    chk("rst_valid", 64'(pv32), 64'd0);
    chk("rst_data", 64'(pd32), 64'd0);
    chk("rst_fault", 64'(pf32), 64'd0);
    @(negedge clk);
    rst = 1'b0; rv32 = 1'b0; rv64 = 1'b0;
    #1;
    chk("post_rst_ready32", 64'(rr32), 64'd1);
    chk("post_rst_ready64", 64'(rr64), 64'd1);
    chk("post_rst_reads", 64'(rd32 + rd64), 64'd0);

    m32[32'h100] = 32'hDEADBEEF;
    run_ok32("lw", 32'h100, F3_LW, 32'h100, 32'hDEADBEEF);

    run_fault32("f3_111", 32'h100, 3'b111);
    run_fault32("ld_on32", 32'h100, F3_LD);

    m32[32'h100] = 32'h80FF1234;
    run_ok32("lb", 32'h103, F3_LB, 32'h100, 32'hFFFFFF80);
    run_ok32("lbu", 32'h103, F3_LBU, 32'h100, 32'h00000080);
    run_ok32("lh", 32'h102, F3_LH, 32'h100, 32'hFFFF80FF);
    run_ok32("lhu", 32'h102, F3_LHU, 32'h100, 32'h000080FF);
    run_ok32("lb0", 32'h100, F3_LB, 32'h100, 32'h00000034);

    m32[32'h100] = 32'hAB000000;
    m32[32'h104] = 32'h000000CD;
`ifdef MISALIGNED_LOAD_EN
    r0 = rd32;
    req32(32'h103, F3_LH);
    chk("split_T_rden", 64'(me32), 64'd1);
    chk("split_T_addr", 64'(ma32), 64'h100);
    cyc();
    chk("split_T1_rden", 64'(me32), 64'd1);
    chk("split_T1_addr", 64'(ma32), 64'h104);
    chk("split_T1_valid", 64'(pv32), 64'd0);
    cyc();
    chk("split_T2_valid", 64'(pv32), 64'd0);
    chk("split_T2_rden", 64'(me32), 64'd0);
    cyc();
    chk("split_T3_valid", 64'(pv32), 64'd1);
    chk("split_T3_data", 64'(pd32), 64'hFFFFCDAB);
    chk("split_T3_fault", 64'(pf32), 64'd0);
    cyc();
    chk("split_T4_valid", 64'(pv32), 64'd0);
    chk("split_reads", 64'(rd32 - r0), 64'd2);

    // Reset while the second read is outstanding
    req32(32'h103, F3_LH);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_rd1_ready", 64'(rr32), 64'd0);
    chk("rst_rd1_valid", 64'(pv32), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rd1_idle_ready", 64'(rr32), 64'd1);
    chk("rst_rd1_idle_valid", 64'(pv32), 64'd0);
    chk("rst_rd1_data", 64'(pd32), 64'd0);
    cyc();
    chk("rst_rd1_no_pulse", 64'(pv32), 64'd0);
`else
    run_fault32("mis_lh", 32'h103, F3_LH);
    run_fault32("mis_lw", 32'h102, F3_LW);
`endif

    // Reset in RD0 with the split read that would otherwise be issued there
    m32[32'h100] = 32'h11223344;
    req32(32'h103, F3_LH);
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_rd0_rden", 64'(me32), 64'd0);
    chk("rst_rd0_ready", 64'(rr32), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rd0_idle_ready", 64'(rr32), 64'd1);
    chk("rst_rd0_valid", 64'(pv32), 64'd0);
    cyc();
    chk("rst_rd0_no_pulse", 64'(pv32), 64'd0);
    cyc();
    chk("rst_rd0_no_pulse2", 64'(pv32), 64'd0);

    // Normal operation resumes after reset
    run_ok32("lw_after_rst", 32'h100, F3_LW, 32'h100, 32'h11223344);

    m64[32'h0] = 64'h8765432100000000;
    m64[32'h8] = 64'h0123456789ABCDEF;
    run_ok64("lwu64", 32'h4, F3_LWU, 32'h0, 64'h0000000087654321);
    run_ok64("lw64", 32'h4, F3_LW, 32'h0, 64'hFFFFFFFF87654321);
    run_ok64("ld64", 32'h8, F3_LD, 32'h8, 64'h0123456789ABCDEF);
    run_ok64("lbu64", 32'hF, F3_LBU, 32'h8, 64'h0000000000000001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
